cpu_exec: RTL

//  Execute/writeback stage of the 8-bit accumulator CPU. Accepts one decoded

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/cpu_alu.sv | 25 ++
 rtl/cpu_exec.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU execute stage:
// opcode/destination encodings, default widths and FSM state encoding.
package cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int PC_W_DEF   = 4;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_MOV  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_NEG  = 3'd4;
  localparam logic [2:0] OP_SWP  = 3'd5;
  localparam logic [2:0] OP_SAV  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  localparam logic [2:0] DEST_NONE = 3'd0;
  localparam logic [2:0] DEST_ACC  = 3'd1;
  localparam logic [2:0] DEST_BAK  = 3'd2;
  localparam logic [2:0] DEST_OUT  = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_OUT_WAIT = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

  // Only the ALU operations route their result to a destination.
  function automatic logic op_uses_dest(input logic [2:0] op);
    return (op == OP_MOV) || (op == OP_ADD) || (op == OP_SUB) || (op == OP_NEG);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the execute stage: (op, acc, src) -> result.
// Arithmetic wraps modulo 2^DATA_W; carry and borrow are not produced.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] src_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = acc_i;
    case (op_i)
      OP_MOV:  result_o = src_i;
      OP_ADD:  result_o = acc_i + src_i;
      OP_SUB:  result_o = acc_i - src_i;
      OP_NEG:  result_o = '0 - src_i;
      default: result_o = acc_i;
    endcase
  end

endmodule

// File: rtl/cpu_exec.sv
// Execute/writeback stage: latches one decoded instruction, updates ACC/BAK,
// drives the output port with a valid/ready handshake and returns the next PC.
module cpu_exec
  import cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src_value,
  input  logic [2:0]        in_operation,
  input  logic [2:0]        in_out_dest,
  input  logic              in_flow,
  input  logic [PC_W-1:0]   in_jump,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              pc_valid,
  output logic [PC_W-1:0]   next_pc,
  output logic [DATA_W-1:0] acc,
  output logic [DATA_W-1:0] bak,
  output logic              acc_zero,
  output logic              halted
);

  state_e            state_q;
  logic [DATA_W-1:0] src_q;
  logic [2:0]        op_q;
  logic [2:0]        dest_q;
  logic              flow_q;
  logic [PC_W-1:0]   jump_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] bak_q, bak_d;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              pc_valid_q;
  logic [PC_W-1:0]   next_pc_q, next_pc_d;
  logic              halted_q;
  logic [DATA_W-1:0] alu_result;
  logic              to_out;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i     (op_q),
    .acc_i    (acc_q),
    .src_i    (src_q),
    .result_o (alu_result)
  );

  // Writeback of the latched instruction; only committed in EXEC.
  always_comb begin
    acc_d = acc_q;
    bak_d = bak_q;
    case (op_q)
      OP_SWP: begin
        acc_d = bak_q;
        bak_d = acc_q;
      end
      OP_SAV: bak_d = acc_q;
      OP_MOV, OP_ADD, OP_SUB, OP_NEG: begin
        if (dest_q == DEST_ACC) begin
          acc_d = alu_result;
        end else if (dest_q == DEST_BAK) begin
          bak_d = alu_result;
        end
      end
      default: ;
    endcase
  end

  // The branch test uses ACC after this instruction's writeback.
  always_comb begin
    if (flow_q && (acc_d == '0)) begin
      next_pc_d = jump_q;
    end else begin
      next_pc_d = pc_q + PC_W'(1);
    end
  end

  assign to_out = op_uses_dest(op_q) && (dest_q == DEST_OUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      op_q        <= OP_NOP;
      dest_q      <= DEST_NONE;
      flow_q      <= 1'b0;
      jump_q      <= '0;
      pc_q        <= '0;
      acc_q       <= '0;
      bak_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      pc_valid_q  <= 1'b0;
      next_pc_q   <= '0;
      halted_q    <= 1'b0;
    end else begin
      pc_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            src_q   <= in_src_value;
            op_q    <= in_operation;
            dest_q  <= in_out_dest;
            flow_q  <= in_flow;
            jump_q  <= in_jump;
            pc_q    <= in_pc;
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_q == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALTED;
          end else begin
            acc_q     <= acc_d;
            bak_q     <= bak_d;
            next_pc_q <= next_pc_d;
            if (to_out) begin
              out_data_q  <= alu_result;
              out_valid_q <= 1'b1;
              state_q     <= ST_OUT_WAIT;
            end else begin
              pc_valid_q <= 1'b1;
              state_q    <= ST_IDLE;
            end
          end
        end
        ST_OUT_WAIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            pc_valid_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        ST_HALTED: state_q <= ST_HALTED;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign pc_valid  = pc_valid_q;
  assign next_pc   = next_pc_q;
  assign acc       = acc_q;
  assign bak       = bak_q;
  assign acc_zero  = (acc_q == '0);
  assign halted    = halted_q;

endmodule
